// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache AXI arbiter.
//   arb_state_e : read-channel arbitration states
//   GNT_I/GNT_D : encoding of the granted side (round-robin bookkeeping)
//   DEF_I_ID/DEF_D_ID : default AXI IDs for icache / dcache bursts
package cache_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_AR,
    I_R,
    D_AR,
    D_R
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [3:0] DEF_I_ID = 4'd0;
  localparam logic [3:0] DEF_D_ID = 4'd1;

endpackage

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master port between the icache and dcache burst engines.
// Read side: one burst outstanding at a time, arbitrated in IDLE with one
// cycle of decision latency; AR and R are muxed from the granted side.
// Write side: dcache AW/W/B forwarded combinationally with a fixed AWID.
//
// Ports:
//   clk, rst (async, active-low)
//   i_ar*/i_r*  : icache refill read channel (slave side)
//   d_ar*/d_r*  : dcache refill read channel (slave side)
//   d_aw*/d_w*/d_b* : dcache write-back channels (slave side)
//   m_*         : shared AXI master port towards the interconnect
//
// Build option: CACHE_ARB_RR_EN selects round-robin arbitration with a
// last_grant register and a sticky m_rid mismatch flag; otherwise dcache
// always wins a simultaneous request.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int unsigned     ID_W = 4,
  parameter logic [ID_W-1:0] I_ID = ID_W'(DEF_I_ID),
  parameter logic [ID_W-1:0] D_ID = ID_W'(DEF_D_ID)
) (
  input  logic            clk,
  input  logic            rst,
  // icache read
  input  logic [31:0]     i_araddr,
  input  logic [3:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic            i_arvalid,
  output logic            i_arready,
  output logic [31:0]     i_rdata,
  output logic            i_rlast,
  output logic            i_rvalid,
  input  logic            i_rready,
  // dcache read
  input  logic [31:0]     d_araddr,
  input  logic [3:0]      d_arlen,
  input  logic [2:0]      d_arsize,
  input  logic            d_arvalid,
  output logic            d_arready,
  output logic [31:0]     d_rdata,
  output logic            d_rlast,
  output logic            d_rvalid,
  input  logic            d_rready,
  // dcache write-back
  input  logic [31:0]     d_awaddr,
  input  logic [3:0]      d_awlen,
  input  logic [2:0]      d_awsize,
  input  logic            d_awvalid,
  output logic            d_awready,
  input  logic [31:0]     d_wdata,
  input  logic [3:0]      d_wstrb,
  input  logic            d_wlast,
  input  logic            d_wvalid,
  output logic            d_wready,
  output logic            d_bvalid,
  input  logic            d_bready,
  // AXI master
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [3:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [31:0]     m_rdata,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic [ID_W-1:0] m_awid,
  output logic [31:0]     m_awaddr,
  output logic [3:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic            m_bvalid,
  output logic            m_bready
);

  arb_state_e state_q, state_d;
  logic       pick_d, pick_i;

`ifdef CACHE_ARB_RR_EN
  logic last_grant_q;
  logic rid_err_q;

  // On a tie the side that was not granted last wins.
  assign pick_d = d_arvalid && (!i_arvalid || (last_grant_q == GNT_I));
`else
  // Single outstanding burst: R beats are routed by state, not by ID.
  logic unused_rid;
  assign unused_rid = ^m_rid;
  assign pick_d     = d_arvalid;
`endif
  assign pick_i = i_arvalid && !pick_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    i_arready = 1'b0;
    i_rdata   = '0;
    i_rlast   = 1'b0;
    i_rvalid  = 1'b0;
    d_arready = 1'b0;
    d_rdata   = '0;
    d_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Decision only; AR is presented from the next cycle.
        if (pick_d)      state_d = D_AR;
        else if (pick_i) state_d = I_AR;
      end
      I_AR: begin
        m_arid    = I_ID;
        m_araddr  = i_araddr;
        m_arlen   = i_arlen;
        m_arsize  = i_arsize;
        m_arvalid = i_arvalid;
        i_arready = m_arready;
        if (i_arvalid && m_arready) state_d = I_R;
      end
      I_R: begin
        i_rdata  = m_rdata;
        i_rlast  = m_rlast;
        i_rvalid = m_rvalid;
        m_rready = i_rready;
        if (m_rvalid && i_rready && m_rlast) state_d = IDLE;
      end
      D_AR: begin
        m_arid    = D_ID;
        m_araddr  = d_araddr;
        m_arlen   = d_arlen;
        m_arsize  = d_arsize;
        m_arvalid = d_arvalid;
        d_arready = m_arready;
        if (d_arvalid && m_arready) state_d = D_R;
      end
      D_R: begin
        d_rdata  = m_rdata;
        d_rlast  = m_rlast;
        d_rvalid = m_rvalid;
        m_rready = d_rready;
        if (m_rvalid && d_rready && m_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant_q <= GNT_I;
    else if ((state_q == IDLE) && (pick_d || pick_i))
      last_grant_q <= pick_d ? GNT_D : GNT_I;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rid_err_q <= 1'b0;
    else if (m_rvalid && ((state_q == I_R) || (state_q == D_R)) &&
             (m_rid != ((state_q == D_R) ? D_ID : I_ID)))
      rid_err_q <= 1'b1;
  end

  rid_sticky: assert property (@(posedge clk) disable iff (!rst) !rid_err_q);
`endif

  // Write-back path: independent of the read arbitration.
  assign m_awid    = D_ID;
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awvalid = d_awvalid;
  assign d_awready = m_awready;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = d_wvalid;
  assign d_wready  = m_wready;
  assign d_bvalid  = m_bvalid;
  assign m_bready  = d_bready;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Self-checking bench for cache_axi_arbiter: randomized requesters, a
// behavioural AXI slave and a transaction-level model of the expected
// arbitration order, AR fields and per-side R beat streams.
module tb_cache_axi_arbiter;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, m_araddr, m_rdata;
  logic [3:0]  i_arlen, d_arlen, m_arlen, m_arid, m_rid;
  logic [2:0]  i_arsize, d_arsize, m_arsize;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [31:0] d_awaddr, d_wdata, m_awaddr, m_wdata;
  logic [3:0]  d_awlen, d_wstrb, m_awlen, m_wstrb, m_awid;
  logic [2:0]  d_awsize, m_awsize;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  cache_axi_arbiter #(.ID_W(4), .I_ID(4'd0), .D_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  typedef struct {logic [31:0] addr; logic [3:0] len; logic [2:0] size;} req_t;
  typedef struct {logic [31:0] data; logic last;} beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  // requesters
  req_t  ireq[$], dreq[$];
  beat_t iexp[$], dexp[$];
  int    i_beats = 0, d_beats = 0;
  int unsigned rdy_pct = 70, rv_pct = 70, ar_pct = 70;
  int    stall = 0, ar_hold = 0;
  // reference model: owner -1 none, 0 icache, 1 dcache
  int    owner = -1;
  bit    ar_open = 0, last_d = 0;
  req_t  cur;
  // AXI read slave
  bit          s_busy = 0, s_rv = 0;
  logic [31:0] s_addr = '0;
  logic [3:0]  s_len = '0, s_beat = '0, s_id = '0;
  // write-back source / sink
  bit          w_on = 0, aw_done = 0, b_pend = 0;
  int          w_idx = 0, wr_cnt = 0, b_got = 0;
  logic [31:0] w_addr = '0, w_data = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a, input logic [3:0] k);
    return (a + {26'd0, k, 2'b00}) ^ 32'hC0DE_0000;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom & 32'hFFFF_FFFC;
    r.len  = 4'($urandom_range(15));
    r.size = 3'($urandom_range(7));
    return r;
  endfunction

  function automatic bit d_wins_tie();
`ifdef CACHE_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic start_write();
    w_on = 1; aw_done = 0; w_idx = 0;
    w_addr = $urandom & 32'hFFFF_FFFC; w_data = $urandom;
  endtask

  task automatic drive();
    @(negedge clk);
    i_arvalid = ireq.size() > 0;
    if (i_arvalid) begin i_araddr = ireq[0].addr; i_arlen = ireq[0].len; i_arsize = ireq[0].size; end
    else begin i_araddr = '0; i_arlen = '0; i_arsize = '0; end
    d_arvalid = dreq.size() > 0;
    if (d_arvalid) begin d_araddr = dreq[0].addr; d_arlen = dreq[0].len; d_arsize = dreq[0].size; end
    else begin d_araddr = '0; d_arlen = '0; d_arsize = '0; end
    i_rready  = (stall == 0) && ($urandom_range(99) < rdy_pct);
    d_rready  = (stall == 0) && ($urandom_range(99) < rdy_pct);
    m_arready = !s_busy && (ar_hold == 0) && ($urandom_range(99) < ar_pct);
    if (s_busy && !s_rv) s_rv = $urandom_range(99) < rv_pct;
    m_rvalid = s_rv;
    m_rid    = s_id;
    m_rdata  = s_rv ? data_of(s_addr, s_beat) : '0;
    m_rlast  = s_rv && (s_beat == s_len);
    d_awvalid = w_on && !aw_done;
    d_awaddr  = d_awvalid ? w_addr : '0;
    d_awlen   = d_awvalid ? 4'd7 : '0;
    d_awsize  = d_awvalid ? 3'd2 : '0;
    d_wvalid  = w_on && (w_idx < 8);
    d_wdata   = d_wvalid ? w_data : '0;
    d_wstrb   = d_wvalid ? 4'hF : '0;
    d_wlast   = d_wvalid && (w_idx == 7);
    d_bready  = 1'($urandom_range(1));
    m_awready = 1'($urandom_range(1));
    m_wready  = $urandom_range(99) < 70;
    m_bvalid  = b_pend;
  endtask

  task automatic observe();
    logic [48:0] rexp;
    logic        own_rdy;
    beat_t       e;
    rexp = '0;
    if (owner >= 0 && ar_open)
      rexp = {1'b1, ((owner == 1) ? D_ID : I_ID), cur.addr, cur.len, cur.size,
              (owner == 0) && m_arready, (owner == 1) && m_arready, 3'b000};
    else if (owner >= 0) begin
      own_rdy = (owner == 1) ? d_rready : i_rready;
      rexp = {44'd0, own_rdy, (owner == 0) && m_rvalid, (owner == 1) && m_rvalid};
    end
    check("rd_ctl", 128'({m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
                          i_arready, d_arready, m_rready, i_rvalid, d_rvalid}), 128'(rexp));
    check("wr_pass",
          128'({m_awid, m_awaddr, m_awlen, m_awsize, m_awvalid, m_wdata, m_wstrb, m_wlast,
                m_wvalid, m_bready, d_awready, d_wready, d_bvalid}),
          128'({D_ID, d_awaddr, d_awlen, d_awsize, d_awvalid, d_wdata, d_wstrb, d_wlast,
                d_wvalid, d_bready, m_awready, m_wready, m_bvalid}));
    if (i_rvalid && i_rready) begin
      i_beats++;
      if (iexp.size() == 0) check("i_beat_extra", 128'(i_rvalid), 128'(0));
      else begin e = iexp.pop_front(); check("i_beat", 128'({i_rlast, i_rdata}), 128'({e.last, e.data})); end
    end
    if (d_rvalid && d_rready) begin
      d_beats++;
      if (dexp.size() == 0) check("d_beat_extra", 128'(d_rvalid), 128'(0));
      else begin e = dexp.pop_front(); check("d_beat", 128'({d_rlast, d_rdata}), 128'({e.last, e.data})); end
    end
    // reference model advance
    if (owner < 0) begin
      if (dreq.size() > 0 && (ireq.size() == 0 || d_wins_tie())) begin owner = 1; cur = dreq[0]; end
      else if (ireq.size() > 0) begin owner = 0; cur = ireq[0]; end
      if (owner >= 0) begin ar_open = 1; last_d = (owner == 1); end
    end else if (ar_open) begin
      if (m_arready) begin
        ar_open = 0;
        for (int k = 0; k <= int'(cur.len); k++) begin
          e.data = data_of(cur.addr, 4'(k));
          e.last = (k == int'(cur.len));
          if (owner == 1) dexp.push_back(e); else iexp.push_back(e);
        end
      end
    end else if (m_rvalid && m_rlast && ((owner == 1) ? d_rready : i_rready)) owner = -1;
    // requesters
    if (i_arvalid && i_arready) void'(ireq.pop_front());
    if (d_arvalid && d_arready) void'(dreq.pop_front());
    // AXI read slave
    if (m_rvalid && m_rready) begin
      if (s_beat == s_len) s_busy = 0;
      s_beat++; s_rv = 0;
    end
    if (m_arvalid && m_arready) begin
      s_busy = 1; s_addr = m_araddr; s_len = m_arlen; s_id = m_arid; s_beat = '0;
    end
    // write-back source and sink
    if (d_awvalid && d_awready) aw_done = 1;
    if (d_wvalid && d_wready) begin w_idx++; w_data = $urandom; end
    if (m_wvalid && m_wready) begin wr_cnt++; if (m_wlast) b_pend = 1; end
    if (m_bvalid && m_bready) begin b_pend = 0; b_got++; w_on = 0; end
    if (stall > 0) stall--;
    if (ar_hold > 0 && m_arvalid) ar_hold--;
  endtask

  task automatic cycle();
    drive();
    #1;
    observe();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((ireq.size() > 0 || dreq.size() > 0 || iexp.size() > 0 || dexp.size() > 0 ||
            owner >= 0 || s_busy || w_on) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 128'(n < budget), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 128'({m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast,
                     d_rlast, m_arid, m_araddr, m_arlen, m_arsize, i_rdata, d_rdata}), 128'(0));
  endtask

  initial begin
    req_t r;
    int   b0, n;
    rst = 1'b0;
    {i_araddr, i_arlen, i_arsize, i_arvalid, i_rready} = '0;
    {d_araddr, d_arlen, d_arsize, d_arvalid, d_rready} = '0;
    {m_arready, m_rid, m_rdata, m_rlast, m_rvalid} = '0;
    {d_awaddr, d_awlen, d_awsize, d_awvalid, d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready} = '0;
    {m_awready, m_wready, m_bvalid} = '0;
    #1;
    check_reset_outputs("reset_rd");
    check("reset_wr", 128'({m_awaddr, m_awvalid, m_wdata, m_wvalid, m_wlast, m_bready,
                            d_awready, d_wready, d_bvalid}), 128'(0));
    cycle(); cycle();
    rst = 1'b1;

    // icache-only 8-beat burst
    b0 = i_beats;
    r.addr = 32'h1FC0_0000; r.len = 4'd7; r.size = 3'd2;
    ireq.push_back(r);
    drain(200);
    check("icache_beats", 128'(i_beats - b0), 128'(8));

    // simultaneous requests, dcache with a second burst queued behind
    dreq.push_back(rand_req()); dreq.push_back(rand_req()); ireq.push_back(rand_req());
    drain(400);

    // AR held off for 5 cycles in D_AR while icache waits
    ar_hold = 5;
    dreq.push_back(rand_req());
    cycle();
    ireq.push_back(rand_req());
    drain(400);

    // single-beat bursts on both sides
    r.addr = 32'h0000_1000; r.len = 4'd0; r.size = 3'd2;
    dreq.push_back(r); r.addr = 32'h0000_2000; ireq.push_back(r);
    drain(100);

    // receiver stall of 3 cycles mid-burst
    rdy_pct = 100; rv_pct = 100;
    b0 = i_beats;
    r.addr = 32'h0000_4000; r.len = 4'd7; r.size = 3'd2;
    ireq.push_back(r);
    n = 0;
    while (i_beats < b0 + 2 && n < 50) begin cycle(); n++; end
    stall = 3;
    drain(200);
    check("stall_beats", 128'(i_beats - b0), 128'(8));

    // reset asserted during the 3rd beat of an icache burst
    b0 = i_beats;
    r.addr = 32'h0000_8000; ireq.push_back(r);
    n = 0;
    while (i_beats < b0 + 2 && n < 50) begin cycle(); n++; end
    drive();
    #1;
    check("mid_beat_valid", 128'(i_rvalid), 128'(1));
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_burst");
    owner = -1; ar_open = 0; last_d = 0; stall = 0;
    ireq.delete(); dreq.delete(); iexp.delete(); dexp.delete();
    s_busy = 0; s_rv = 0;
    cycle();
    rst = 1'b1;
    b0 = d_beats;
    r.addr = 32'h0000_C000; r.len = 4'd3; dreq.push_back(r);
    drain(100);
    check("post_reset_d_beats", 128'(d_beats - b0), 128'(4));

    // write-back concurrent with an icache read
    rdy_pct = 70; rv_pct = 70;
    wr_cnt = 0; b_got = 0;
    start_write();
    ireq.push_back(rand_req());
    drain(400);
    check("wr_beats", 128'(wr_cnt), 128'(8));
    check("wr_bresp", 128'(b_got), 128'(1));

    // random soak
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(9) == 0 && ireq.size() < 2) ireq.push_back(rand_req());
      if ($urandom_range(9) == 0 && dreq.size() < 2) dreq.push_back(rand_req());
      if (!w_on && $urandom_range(39) == 0) start_write();
      rdy_pct = 40 + $urandom_range(60);
      cycle();
    end
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
Shares one AXI master port between the instruction-cache and data-cache burst engines inside the cache wrapper.
- Arbitrates AR/R between icache and dcache refills, one read burst outstanding at a time.
- Forwards the dcache AW/W/B write-back path unchanged, adding a fixed ID.
- Sits between the cache wrapper's i_*/d_* buses and the SoC AXI interconnect.

Parameters:
- ID_W, 4, AXI ID width.
- I_ID, 4'd0, ARID driven for icache bursts.
- D_ID, 4'd1, ARID/AWID driven for dcache bursts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_araddr/i_arlen/i_arsize/i_arvalid  in  32/4/3/1  icache AR request.
- i_arready  out  1  icache AR accepted.
- i_rdata/i_rlast/i_rvalid  out  32/1/1  icache R beat.
- i_rready  in  1  icache R ready.
- d_araddr/d_arlen/d_arsize/d_arvalid  in  32/4/3/1  dcache AR request.
- d_arready  out  1  dcache AR accepted.
- d_rdata/d_rlast/d_rvalid  out  32/1/1  dcache R beat.
- d_rready  in  1  dcache R ready.
- d_awaddr/d_awlen/d_awsize/d_awvalid, d_wdata/d_wstrb/d_wlast/d_wvalid, d_bready  in  dcache write channels.
- d_awready/d_wready/d_bvalid  out  1  dcache write handshakes.
- m_arid/m_araddr/m_arlen/m_arsize/m_arvalid  out  ID_W/32/4/3/1  AXI AR.
- m_arready  in  1.
- m_rid/m_rdata/m_rlast/m_rvalid  in  ID_W/32/1/1  AXI R.
- m_rready  out  1.
- m_awid/m_awaddr/m_awlen/m_awsize/m_awvalid  out  AXI AW.
- m_awready  in.
- m_wdata/m_wstrb/m_wlast/m_wvalid  out  AXI W.
- m_wready  in.
- m_bvalid  in.
- m_bready  out.

Behaviour:
- State machine: IDLE, I_AR, I_R, D_AR, D_R. Registered state and grant; reset to IDLE.
- IDLE:
  - d_arvalid -> D_AR.
  - else i_arvalid -> I_AR.
  - Fixed priority: dcache wins a simultaneous request.
  - No AR issued in the same cycle as the decision (1-cycle arbitration latency).
- x_AR:
  - m_ar* = granted requester's fields; m_arid = I_ID or D_ID.
  - m_arvalid = granted x_arvalid; x_arready = m_arready.
  - On m_arvalid & m_arready -> x_R.
  - If the granted arvalid drops before handshake (protocol violation), stay in x_AR.
- x_R:
  - x_rdata/x_rlast = m_r*; x_rvalid = m_rvalid; m_rready = x_rready.
  - On m_rvalid & m_rready & m_rlast -> IDLE.
  - Non-granted side's rvalid = 0 and arready = 0 throughout.
- m_rid is ignored for routing (single outstanding burst); it is checked only under the optional feature.
- Outside x_AR: m_arvalid = 0, m_ar* fields = 0.
- Outside x_R: m_rready = 0.
- Write path: pure combinational pass-through, independent of the read FSM. m_awid = D_ID.
- Reset values:
  - All *valid, *ready and *last outputs = 0.
  - Data and address outputs = 0.
  - Write pass-through outputs follow their inputs; they are 0 while inputs are 0.
- Reset asserted mid-burst: FSM forced to IDLE immediately. The remaining beats of the interrupted burst are the interconnect's responsibility, since the system resets together.
- Back-to-back: one idle cycle minimum between rlast and the next AR.
- arlen=0 single-beat burst: rlast on the first beat returns to IDLE.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin. A 1-bit last_grant register (reset 0 = icache) records the side granted last.
  - On a simultaneous request, the side not granted last wins; last_grant updates on entry to x_AR.
  - R beats with m_rid not matching the grant raise a sticky, simulation-only assertion flag.
- Undefined: fixed dcache priority as above; no last_grant register.

Decomposition:
- Shared package cache_axi_pkg:
  - State enum (IDLE, I_AR, I_R, D_AR, D_R).
  - Grant encoding localparams GNT_I=1'b0, GNT_D=1'b1.
  - Default I_ID/D_ID constants.
- No sub-module: the FSM and muxes fit in one module. The write pass-through stays inline.

Test Plan:
- i_arvalid only, i_araddr=0x1FC00000, arlen=7 -> m_arid=0 and address matches; 8 beats routed to i_r*; d_rvalid stays 0; IDLE after rlast.
- i_arvalid and d_arvalid in the same cycle -> dcache burst (m_arid=1) completes first, then the icache AR issues ≥1 cycle after d_rlast. With CACHE_ARB_RR_EN, after a reset (last_grant=0), dcache wins; the next tie goes to icache.
- m_arready held 0 for 5 cycles in D_AR -> m_arvalid stays 1 with stable fields; i_arready=0 throughout.
- Burst with x_rready deasserted for 3 beats -> m_rready mirrors it; no beat lost or duplicated.
- rst low during the 3rd beat of an icache burst -> all valid/ready outputs 0 asynchronously; after release, FSM in IDLE and a new d_ar is granted.
- d_aw/w/b write-back of 8 beats concurrent with an icache read -> both complete; m_awid=1; read sequencing unaffected.
